// File: rtl/hazard_mc_if.sv
// rtl/hazard_mc_if.sv - hazard unit pipeline-control bundle
interface hazard_mc_if #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 4,
    parameter int STAT_W = 16
);
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic              use_rs1_d;
    logic              use_rs2_d;
    logic [REG_AW-1:0] rs1_e;
    logic [REG_AW-1:0] rs2_e;
    logic [REG_AW-1:0] rd_e;
    logic              res_src_e_b0;
    logic              pc_src_e;
    logic              mc_start_e;
    logic [LAT_W-1:0]  mc_lat_e;
    logic [REG_AW-1:0] rd_m;
    logic              reg_write_m;
    logic [REG_AW-1:0] rd_w;
    logic              reg_write_w;
    logic              stat_clr;
    logic              stall_f;
    logic              stall_d;
    logic              stall_e;
    logic              flush_d;
    logic              flush_e;
    logic              flush_m;
    logic [1:0]        forward_a_e;
    logic [1:0]        forward_b_e;
    logic              mc_busy;
    logic [STAT_W-1:0] stall_cycles;

    modport master (
        output rs1_d, rs2_d, use_rs1_d, use_rs2_d, rs1_e, rs2_e, rd_e,
               res_src_e_b0, pc_src_e, mc_start_e, mc_lat_e, rd_m,
               reg_write_m, rd_w, reg_write_w, stat_clr,
        input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               forward_a_e, forward_b_e, mc_busy, stall_cycles
    );

    modport slave (
        input  rs1_d, rs2_d, use_rs1_d, use_rs2_d, rs1_e, rs2_e, rd_e,
               res_src_e_b0, pc_src_e, mc_start_e, mc_lat_e, rd_m,
               reg_write_m, rd_w, reg_write_w, stat_clr,
        output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
               forward_a_e, forward_b_e, mc_busy, stall_cycles
    );
endinterface

// File: rtl/hazard_mc.sv
// rtl/hazard_mc.sv - hazard unit with load-use stall, forwarding and multi-cycle E hold
module hazard_mc #(
    parameter int REG_AW = 5,
    parameter int LAT_W  = 4,
    parameter int STAT_W = 16
) (
    input  logic           clk,
    input  logic           rst,
    hazard_mc_if.slave     bus
);
    logic [LAT_W-1:0]  cnt;
    logic [LAT_W-1:0]  cnt_nxt;
    logic              mc_done;
    logic              mc_done_nxt;
    logic [STAT_W-1:0] stat_q;
    logic [STAT_W-1:0] stat_nxt;
    logic              lw_stall;
    logic              mc_trig;
    logic              busy_raw;
    logic              stall_any;

    function automatic logic [1:0] fwd_sel(
        input logic [REG_AW-1:0] rs,
        input logic [REG_AW-1:0] rd_m,
        input logic              we_m,
        input logic [REG_AW-1:0] rd_w,
        input logic              we_w
    );
        if (we_m && rd_m == rs && rs != '0)
            return 2'b01;
        else if (we_w && rd_w == rs && rs != '0)
            return 2'b10;
        else
            return 2'b00;
    endfunction

    // Hazard detection: load-use match and multi-cycle trigger; the done flag blocks
    // the instruction still sitting in E from re-triggering in its release cycle.
    always_comb begin
        lw_stall = bus.res_src_e_b0 && (bus.rd_e != '0) &&
                   ((bus.use_rs1_d && bus.rs1_d == bus.rd_e) ||
                    (bus.use_rs2_d && bus.rs2_d == bus.rd_e));
        mc_trig  = bus.mc_start_e && (cnt == '0) && !mc_done &&
                   (bus.mc_lat_e >= LAT_W'(2));
        busy_raw = mc_trig || (cnt != '0);
    end

    // Next-state: cnt holds remaining stall cycles after the current one.
    always_comb begin
        cnt_nxt     = cnt;
        mc_done_nxt = 1'b0;
        if (mc_trig) begin
            cnt_nxt     = bus.mc_lat_e - LAT_W'(2);
            mc_done_nxt = (bus.mc_lat_e == LAT_W'(2));
        end else if (cnt != '0) begin
            cnt_nxt     = cnt - LAT_W'(1);
            mc_done_nxt = (cnt == LAT_W'(1));
        end
        stat_nxt = stat_q;
        if (bus.stat_clr)
            stat_nxt = '0;
        else if (stall_any && stat_q != '1)
            stat_nxt = stat_q + STAT_W'(1);
    end

    // State register; reset aborts any hold in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt     <= '0;
            mc_done <= 1'b0;
            stat_q  <= '0;
        end else begin
            cnt     <= cnt_nxt;
            mc_done <= mc_done_nxt;
            stat_q  <= stat_nxt;
        end
    end

    // Outputs, forced quiet while reset is held; the hold overrides branch flushes.
    always_comb begin
        stall_any        = !rst && (lw_stall || busy_raw);
        bus.stall_f      = stall_any;
        bus.stall_d      = stall_any;
        bus.stall_e      = !rst && busy_raw;
        bus.flush_m      = !rst && busy_raw;
        bus.mc_busy      = !rst && busy_raw;
        bus.flush_d      = !rst && bus.pc_src_e && !busy_raw;
        bus.flush_e      = !rst && (lw_stall || bus.pc_src_e) && !busy_raw;
        bus.forward_a_e  = rst ? 2'b00 :
                           fwd_sel(bus.rs1_e, bus.rd_m, bus.reg_write_m, bus.rd_w, bus.reg_write_w);
        bus.forward_b_e  = rst ? 2'b00 :
                           fwd_sel(bus.rs2_e, bus.rd_m, bus.reg_write_m, bus.rd_w, bus.reg_write_w);
        bus.stall_cycles = stat_q;
    end
endmodule

// File: tb/tb_hazard_mc.sv
// tb/tb_hazard_mc.sv - self-checking bench for hazard_mc
module tb_hazard_mc;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    hazard_mc_if #(.REG_AW(5), .LAT_W(4), .STAT_W(16)) u_if ();
    hazard_mc_if #(.REG_AW(5), .LAT_W(4), .STAT_W(3))  u_if3 ();

    hazard_mc #(.REG_AW(5), .LAT_W(4), .STAT_W(16)) u_dut (.clk(clk), .rst(rst), .bus(u_if.slave));
    hazard_mc #(.REG_AW(5), .LAT_W(4), .STAT_W(3))  u_dut3 (.clk(clk), .rst(rst), .bus(u_if3.slave));

    // {stall_f, stall_d, stall_e, flush_d, flush_e, flush_m, mc_busy}
    wire [6:0] obs  = {u_if.stall_f, u_if.stall_d, u_if.stall_e, u_if.flush_d,
                       u_if.flush_e, u_if.flush_m, u_if.mc_busy};
    wire [6:0] obs3 = {u_if3.stall_f, u_if3.stall_d, u_if3.stall_e, u_if3.flush_d,
                       u_if3.flush_e, u_if3.flush_m, u_if3.mc_busy};
    localparam logic [6:0] V_HOLD = 7'b1110011;

    task automatic clear_inputs;
        u_if.rs1_d = 0; u_if.rs2_d = 0; u_if.use_rs1_d = 0; u_if.use_rs2_d = 0;
        u_if.rs1_e = 0; u_if.rs2_e = 0; u_if.rd_e = 0; u_if.res_src_e_b0 = 0;
        u_if.pc_src_e = 0; u_if.mc_start_e = 0; u_if.mc_lat_e = 0; u_if.rd_m = 0;
        u_if.reg_write_m = 0; u_if.rd_w = 0; u_if.reg_write_w = 0; u_if.stat_clr = 0;
        u_if3.rs1_d = 0; u_if3.rs2_d = 0; u_if3.use_rs1_d = 0; u_if3.use_rs2_d = 0;
        u_if3.rs1_e = 0; u_if3.rs2_e = 0; u_if3.rd_e = 0; u_if3.res_src_e_b0 = 0;
        u_if3.pc_src_e = 0; u_if3.mc_start_e = 0; u_if3.mc_lat_e = 0; u_if3.rd_m = 0;
        u_if3.reg_write_m = 0; u_if3.rd_w = 0; u_if3.reg_write_w = 0; u_if3.stat_clr = 0;
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        clear_inputs();
        rst = 1'b1;
        u_if.res_src_e_b0 = 1; u_if.rd_e = 5; u_if.rs1_d = 5; u_if.use_rs1_d = 1;
        u_if.pc_src_e = 1; u_if.mc_start_e = 1; u_if.mc_lat_e = 4;
        u_if.rs1_e = 7; u_if.rs2_e = 9; u_if.rd_m = 7; u_if.rd_w = 9;
        u_if.reg_write_m = 1; u_if.reg_write_w = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== 7'b0) begin
                failures++;
                $display("FAIL reset_ctrl cyc=%0d got=%b exp=0000000", k, obs);
            end
            checks++;
            if ({u_if.forward_a_e, u_if.forward_b_e} !== 4'b0000) begin
                failures++;
                $display("FAIL reset_fwd got=%b exp=0000", {u_if.forward_a_e, u_if.forward_b_e});
            end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
        @(negedge clk);
        checks++;
        if (u_if.stall_cycles !== 16'd0 || u_if3.stall_cycles !== 3'd0) begin
            failures++;
            $display("FAIL reset_stat got=%0d/%0d exp=0/0", u_if.stall_cycles, u_if3.stall_cycles);
        end
        checks++;
        if (obs !== 7'b0) begin
            failures++;
            $display("FAIL reset_idle got=%b exp=0000000", obs);
        end
        tick();
    endtask

    task automatic test_load_use;
        // use_rs1, rd_e, expected {stall_f, stall_d, flush_e, flush_d}
        logic       tu [3] = '{1'b1, 1'b0, 1'b1};
        logic [4:0] trd[3] = '{5'd5, 5'd5, 5'd0};
        logic [3:0] tex[3] = '{4'b1110, 4'b0000, 4'b0000};
        do_reset();
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            u_if.res_src_e_b0 = 1; u_if.rs1_d = 5;
            u_if.use_rs1_d = tu[i]; u_if.rd_e = trd[i];
            @(negedge clk);
            checks++;
            if ({u_if.stall_f, u_if.stall_d, u_if.flush_e, u_if.flush_d} !== tex[i]) begin
                failures++;
                $display("FAIL load_use case=%0d got=%b exp=%b", i,
                         {u_if.stall_f, u_if.stall_d, u_if.flush_e, u_if.flush_d}, tex[i]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_forwarding;
        logic       twm[3] = '{1'b1, 1'b0, 1'b1};
        logic [4:0] trs[3] = '{5'd7, 5'd7, 5'd0};
        logic [1:0] tex[3] = '{2'b01, 2'b10, 2'b00};
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            u_if.rd_m = trs[i]; u_if.rd_w = trs[i]; u_if.rs1_e = trs[i]; u_if.rs2_e = trs[i];
            u_if.reg_write_w = 1; u_if.reg_write_m = twm[i];
            @(negedge clk);
            checks++;
            if (u_if.forward_a_e !== tex[i] || u_if.forward_b_e !== tex[i]) begin
                failures++;
                $display("FAIL forwarding case=%0d got=%b/%b exp=%b", i,
                         u_if.forward_a_e, u_if.forward_b_e, tex[i]);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_multicycle;
        int lats[3] = '{4, 2, 1};
        for (int i = 0; i < 3; i++) begin
            clear_inputs();
            do_reset();
            u_if.mc_start_e = 1; u_if.mc_lat_e = 4'(lats[i]);
            for (int k = 0; k < lats[i]; k++) begin
                @(negedge clk);
                checks++;
                if (obs !== ((k < lats[i] - 1) ? V_HOLD : 7'b0)) begin
                    failures++;
                    $display("FAIL multicycle lat=%0d cyc=%0d got=%b exp=%b", lats[i], k, obs,
                             (k < lats[i] - 1) ? V_HOLD : 7'b0);
                end
                tick();
            end
            u_if.mc_start_e = 0;
            @(negedge clk);
            checks++;
            if (obs !== 7'b0) begin
                failures++;
                $display("FAIL multicycle_after lat=%0d got=%b exp=0000000", lats[i], obs);
            end
            tick();
        end
        clear_inputs();
    endtask

    task automatic test_branch_hold;
        clear_inputs();
        do_reset();
        u_if.mc_start_e = 1; u_if.mc_lat_e = 4; u_if.pc_src_e = 1;
        @(negedge clk);
        checks++;
        if (obs !== V_HOLD) begin
            failures++;
            $display("FAIL branch_busy got=%b exp=%b", obs, V_HOLD);
        end
        tick(); tick(); tick();
        @(negedge clk);
        checks++;
        if (obs !== 7'b0001100) begin
            failures++;
            $display("FAIL branch_free got=%b exp=0001100", obs);
        end
        tick();
        clear_inputs();
        // load-use and branch together: both flushes plus the stall
        u_if.res_src_e_b0 = 1; u_if.rd_e = 3; u_if.rs2_d = 3; u_if.use_rs2_d = 1; u_if.pc_src_e = 1;
        @(negedge clk);
        checks++;
        if (obs !== 7'b1101100) begin
            failures++;
            $display("FAIL branch_loaduse got=%b exp=1101100", obs);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_stat_saturate;
        clear_inputs();
        do_reset();
        u_if3.res_src_e_b0 = 1; u_if3.rd_e = 5; u_if3.rs1_d = 5; u_if3.use_rs1_d = 1;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            checks++;
            if (u_if3.stall_cycles !== 3'((k + 1 > 7) ? 7 : k + 1)) begin
                failures++;
                $display("FAIL stat_count cyc=%0d got=%0d exp=%0d", k, u_if3.stall_cycles,
                         (k + 1 > 7) ? 7 : k + 1);
            end
        end
        u_if3.stat_clr = 1;
        tick();
        @(negedge clk);
        checks++;
        if (u_if3.stall_cycles !== 3'd0 || u_if3.stall_f !== 1'b1) begin
            failures++;
            $display("FAIL stat_clear got=%0d stall_f=%b exp=0 stall_f=1", u_if3.stall_cycles, u_if3.stall_f);
        end
        tick();
        clear_inputs();
    endtask

    task automatic test_reset_mid_hold;
        clear_inputs();
        do_reset();
        u_if.mc_start_e = 1; u_if.mc_lat_e = 8;
        @(negedge clk);
        checks++;
        if (obs !== V_HOLD) begin
            failures++;
            $display("FAIL midhold_first got=%b exp=%b", obs, V_HOLD);
        end
        tick();
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (obs !== 7'b0) begin
            failures++;
            $display("FAIL midhold_rst got=%b exp=0000000", obs);
        end
        tick();
        rst = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            checks++;
            if (obs !== ((k < 7) ? V_HOLD : 7'b0)) begin
                failures++;
                $display("FAIL midhold_fresh cyc=%0d got=%b exp=%b", k, obs, (k < 7) ? V_HOLD : 7'b0);
            end
            tick();
        end
        clear_inputs();
    endtask

    // Reference: an E instruction of latency L occupies E for max(L,1) cycles and stalls
    // the pipeline for all but its last; a new instruction enters E only once it leaves.
    task automatic test_random;
        int occ = 0;
        int olat = 0;
        int stat = 0;
        logic lw, busy, sf;
        logic [1:0] fa, fb;
        logic [6:0] exp_v;
        clear_inputs();
        do_reset();
        for (int n = 0; n < 600; n++) begin
            rst = ($urandom_range(0, 39) == 0);
            u_if.rs1_d = 5'($urandom_range(0, 7)); u_if.rs2_d = 5'($urandom_range(0, 7));
            u_if.use_rs1_d = 1'($urandom); u_if.use_rs2_d = 1'($urandom);
            u_if.rs1_e = 5'($urandom_range(0, 7)); u_if.rs2_e = 5'($urandom_range(0, 7));
            u_if.rd_e = 5'($urandom_range(0, 7)); u_if.res_src_e_b0 = ($urandom_range(0, 3) == 0);
            u_if.pc_src_e = ($urandom_range(0, 4) == 0); u_if.mc_start_e = 1'($urandom);
            u_if.mc_lat_e = 4'($urandom_range(0, 6));
            u_if.rd_m = 5'($urandom_range(0, 7)); u_if.reg_write_m = 1'($urandom);
            u_if.rd_w = 5'($urandom_range(0, 7)); u_if.reg_write_w = 1'($urandom);
            u_if.stat_clr = ($urandom_range(0, 29) == 0);

            if (!rst && occ == 0 && u_if.mc_start_e) begin
                occ = 1;
                olat = int'(u_if.mc_lat_e);
            end
            busy = !rst && occ != 0 && occ < olat;
            lw = !rst && u_if.res_src_e_b0 && u_if.rd_e != 0 &&
                 ((u_if.use_rs1_d && u_if.rs1_d == u_if.rd_e) || (u_if.use_rs2_d && u_if.rs2_d == u_if.rd_e));
            sf = lw || busy;
            exp_v = {sf, sf, busy, !rst && u_if.pc_src_e && !busy,
                     !rst && (lw || u_if.pc_src_e) && !busy, busy, busy};
            fa = rst ? 2'b00 : (u_if.reg_write_m && u_if.rd_m == u_if.rs1_e && u_if.rs1_e != 0) ? 2'b01 :
                 (u_if.reg_write_w && u_if.rd_w == u_if.rs1_e && u_if.rs1_e != 0) ? 2'b10 : 2'b00;
            fb = rst ? 2'b00 : (u_if.reg_write_m && u_if.rd_m == u_if.rs2_e && u_if.rs2_e != 0) ? 2'b01 :
                 (u_if.reg_write_w && u_if.rd_w == u_if.rs2_e && u_if.rs2_e != 0) ? 2'b10 : 2'b00;

            @(negedge clk);
            checks++;
            if (obs !== exp_v) begin
                failures++;
                $display("FAIL rand_ctrl n=%0d got=%b exp=%b", n, obs, exp_v);
            end
            checks++;
            if (u_if.forward_a_e !== fa || u_if.forward_b_e !== fb) begin
                failures++;
                $display("FAIL rand_fwd n=%0d got=%b/%b exp=%b/%b", n, u_if.forward_a_e, u_if.forward_b_e, fa, fb);
            end
            checks++;
            if (u_if.stall_cycles !== 16'(stat)) begin
                failures++;
                $display("FAIL rand_stat n=%0d got=%0d exp=%0d", n, u_if.stall_cycles, stat);
            end

            if (rst) begin
                occ = 0;
                stat = 0;
            end else begin
                if (u_if.stat_clr) stat = 0;
                else if (sf && stat < 65535) stat++;
                if (occ != 0) occ = (occ >= olat) ? 0 : occ + 1;
            end
            tick();
        end
        rst = 1'b0;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        #1;
        test_reset();
        test_load_use();
        test_forwarding();
        test_multicycle();
        test_branch_hold();
        test_stat_saturate();
        test_reset_mid_hold();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
